pipe_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage pipelined CPU. Generates the PC / IF-ID write enable (`wpcir`), the ID/EX bubble, and the IF/ID flush. It covers the post-reset boot hold, load-use interlocks, the multi-cycle multiply/divide busy window, and taken-branch squash. It sits beside the ID stage and drives `wpcir` into the PC register and the IF/ID pipeline register. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl_pkg.sv | 19 +
 rtl/pipe_stall_ctrl_if.sv | 42 ++++
 rtl/pipe_stall_ctrl_md_busy_counter.sv | 28 ++
 rtl/pipe_stall_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Imported by the interface, the top and the md counter.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MDBUSY
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MD_LAT_DEF      = 8;
  localparam int BOOT_CYCLES_DEF = 1;

  localparam int MD_CNT_W   = 6;
  localparam int BOOT_CNT_W = 4;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// ID/EX hazard inputs and stall-control outputs between the ID
// stage (master) and the sequencing controller (slave).
interface pipe_stall_ctrl_if;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [4:0]  ex_rn;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic        id_md_start;
  logic        id_md_read;
  logic        id_branch_taken;

  logic        wpcir;
  logic        bubble;
  logic        flush_ifid;
  logic        md_busy;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output ex_rn, ex_wreg, ex_m2reg,
    output id_md_start, id_md_read,
    output id_branch_taken,
    input  wpcir, bubble, flush_ifid,
    input  md_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  ex_rn, ex_wreg, ex_m2reg,
    input  id_md_start, id_md_read,
    input  id_branch_taken,
    output wpcir, bubble, flush_ifid,
    output md_busy, stall_cycles
  );

endinterface

// File: rtl/pipe_stall_ctrl_md_busy_counter.sv
// Load/decrement counter timing the multiply/divide busy window.
// tc is high while the count sits at 1, i.e. on the last busy cycle.
module md_busy_counter
  import pipe_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic                tc
);

  logic [MD_CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == MD_CNT_W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: boot hold, load-use and mul/div
// interlocks, taken-branch squash and a saturating stall counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEF,
  parameter int MD_LAT      = MD_LAT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  pipe_stall_ctrl_if.slave bus
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST =
    BOOT_CNT_W'(BOOT_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] MD_LOAD =
    MD_CNT_W'(MD_LAT);

  state_t                state_q;
  state_t                state_d;
  logic [BOOT_CNT_W-1:0] boot_q;
  logic [31:0]           stall_q;

  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic mh;
  logic stall;
  logic issue;
  logic md_tc;
  logic boot_inc;
  logic wpcir;
  logic bubble;
  logic flush;

  assign rs_hit = bus.id_use_rs && (bus.id_rs == bus.ex_rn);
  assign rt_hit = bus.id_use_rt && (bus.id_rt == bus.ex_rn);

  assign lu = bus.ex_wreg && bus.ex_m2reg
           && (bus.ex_rn != REG_ZERO)
           && (rs_hit || rt_hit);

  assign mh = (state_q == MDBUSY)
           && (bus.id_md_read || bus.id_md_start);

  // BOOT ignores every ID input, so hazards only count outside it
  assign stall = (state_q != BOOT) && (lu || mh);
  assign issue = (state_q == RUN) && bus.id_md_start && !stall;

  always_comb begin
    state_d  = state_q;
    wpcir    = 1'b0;
    bubble   = 1'b1;
    flush    = 1'b0;
    boot_inc = 1'b0;
    unique case (state_q)
      BOOT: begin
        boot_inc = 1'b1;
        if (boot_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          wpcir  = 1'b1;
          bubble = 1'b0;
          flush  = bus.id_branch_taken;
        end
        if (issue) state_d = MDBUSY;
      end
      MDBUSY: begin
        if (!stall) begin
          wpcir  = 1'b1;
          bubble = 1'b0;
          flush  = bus.id_branch_taken;
        end
        if (md_tc) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BOOT;
      boot_q  <= '0;
    end else begin
      state_q <= state_d;
      if (boot_inc) boot_q <= boot_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stall && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  md_busy_counter u_md_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (issue),
    .load_val (MD_LOAD),
    .dec      (state_q == MDBUSY),
    .tc       (md_tc)
  );

  assign bus.wpcir        = wpcir;
  assign bus.bubble       = bubble;
  assign bus.flush_ifid   = flush;
  assign bus.md_busy      = (state_q == MDBUSY);
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: vector table for the RUN-state
// hazard decode plus sequences for boot, mul/div, reset and saturation.
module tb_pipe_stall_ctrl;

  logic clock;
  logic reset;

  int total;
  int passed;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .BOOT_CYCLES (1),
    .MD_LAT      (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rn;
    logic       wreg;
    logic       m2reg;
    logic       br;
    logic       w;
    logic       b;
    logic       f;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_use_rs       = 1'b0;
    bus.id_use_rt       = 1'b0;
    bus.ex_rn           = 5'd0;
    bus.ex_wreg         = 1'b0;
    bus.ex_m2reg        = 1'b0;
    bus.id_md_start     = 1'b0;
    bus.id_md_read      = 1'b0;
    bus.id_branch_taken = 1'b0;
  endtask

  // lw $3 in EX, ID reads rs=3
  task automatic drive_lu();
    bus.id_rs     = 5'd3;
    bus.id_use_rs = 1'b1;
    bus.ex_rn     = 5'd3;
    bus.ex_wreg   = 1'b1;
    bus.ex_m2reg  = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    bus.id_rs           = v.rs;
    bus.id_rt           = v.rt;
    bus.id_use_rs       = v.urs;
    bus.id_use_rt       = v.urt;
    bus.ex_rn           = v.rn;
    bus.ex_wreg         = v.wreg;
    bus.ex_m2reg        = v.m2reg;
    bus.id_branch_taken = v.br;
  endtask

  int busy_n;

  initial begin
    total  = 0;
    passed = 0;
    // rs rt urs urt rn wreg m2reg br | w b f
    vecs[0] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0};
    vecs[1] = '{5'd3, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b0};
    vecs[2] = '{5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0};
    vecs[3] = '{5'd3, 5'd2, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0};
    vecs[4] = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b0};
    vecs[5] = '{5'd3, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b0};
    vecs[6] = '{5'd3, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0};
    vecs[7] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b1};
    vecs[8] = '{5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b0};
    vecs[9] = '{5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0};

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // BOOT: ID inputs ignored
    drive_lu();
    bus.id_branch_taken = 1'b1;
    #1;
    chk("boot_wpcir", 32'(bus.wpcir), 32'd0);
    chk("boot_bubble", 32'(bus.bubble), 32'd1);
    chk("boot_flush", 32'(bus.flush_ifid), 32'd0);
    chk("boot_md_busy", 32'(bus.md_busy), 32'd0);
    chk("boot_stall_cnt", bus.stall_cycles, 32'd0);
    idle();

    @(negedge clock);
    #1;
    chk("run_wpcir", 32'(bus.wpcir), 32'd1);
    chk("run_bubble", 32'(bus.bubble), 32'd0);
    chk("run_stall_cnt", bus.stall_cycles, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clock);
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_wpcir", i), 32'(bus.wpcir), 32'(vecs[i].w));
      chk($sformatf("vec%0d_bubble", i), 32'(bus.bubble), 32'(vecs[i].b));
      chk($sformatf("vec%0d_flush", i), 32'(bus.flush_ifid), 32'(vecs[i].f));
    end
    @(negedge clock);
    idle();
    #1;
    chk("table_stall_cnt", bus.stall_cycles, 32'd3);

    // branch blocked by LU, resolved the following cycle
    @(negedge clock);
    drive_lu();
    bus.id_branch_taken = 1'b1;
    #1;
    chk("br_lu_flush", 32'(bus.flush_ifid), 32'd0);
    chk("br_lu_wpcir", 32'(bus.wpcir), 32'd0);
    @(negedge clock);
    idle();
    bus.id_branch_taken = 1'b1;
    #1;
    chk("br_go_flush", 32'(bus.flush_ifid), 32'd1);
    chk("br_go_wpcir", 32'(bus.wpcir), 32'd1);
    chk("br_stall_cnt", bus.stall_cycles, 32'd4);

    // mult then mfhi held in ID
    @(negedge clock);
    idle();
    bus.id_md_start = 1'b1;
    #1;
    chk("md_issue_wpcir", 32'(bus.wpcir), 32'd1);
    chk("md_issue_busy", 32'(bus.md_busy), 32'd0);
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      idle();
      bus.id_md_read = 1'b1;
      if (busy_n == 2) drive_lu();
      #1;
      if (!bus.md_busy) break;
      busy_n++;
      chk("md_hold_wpcir", 32'(bus.wpcir), 32'd0);
    end
    chk("md_busy_len", 32'(busy_n), 32'd8);
    chk("mfhi_go_wpcir", 32'(bus.wpcir), 32'd1);
    chk("mfhi_go_bubble", 32'(bus.bubble), 32'd0);
    @(negedge clock);
    idle();
    #1;
    chk("md_stall_cnt", bus.stall_cycles, 32'd12);

    // reset on the 3rd MDBUSY cycle
    bus.id_md_start = 1'b1;
    @(negedge clock);
    idle();
    #1;
    chk("rst_md_busy1", 32'(bus.md_busy), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_md_busy3", 32'(bus.md_busy), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_md_busy_low", 32'(bus.md_busy), 32'd0);
    chk("rst_wpcir", 32'(bus.wpcir), 32'd0);
    chk("rst_stall_cnt", bus.stall_cycles, 32'd0);
    @(negedge clock);
    #1;
    chk("rst_run_wpcir", 32'(bus.wpcir), 32'd1);

    // saturation
    @(negedge clock);
    force dut.stall_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_q;
    chk("sat_preload", bus.stall_cycles, 32'hFFFF_FFFE);
    drive_lu();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk($sformatf("sat_%0d", i), bus.stall_cycles, 32'hFFFF_FFFF);
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
